i2c_slave: RTL

//  I2C responder: the target-side counterpart of the team's I2C master. Decodes START/STOP, matches a
//  7-bit device address, ACKs it, then exposes a byte-wide register port. Write transactions: first byte

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/dd_sync.sv | 30 +++
 rtl/i2c_slave.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK bit levels and
// bit-counter markers used by the target-side controller.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE_S,
        ADDR_S,
        ADDR_ACK_S,
        PTR_S,
        WDATA_S,
        RDATA_S,
        RACK_S
    } state_t;

    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;

    localparam int         CNT_W         = 4;
    localparam logic [3:0] CNT_BYTE_LAST = 4'd7;   // index of the 8th data bit
    localparam logic [3:0] CNT_ACK       = 4'd8;   // byte complete, ACK slot not yet driven
    localparam logic [3:0] CNT_HOLD      = 4'd9;   // ACK slot driven / read lead-in

    localparam logic [7:0] RD_IDLE_BYTE  = 8'hFF;  // sent when read data is late

endpackage

// File: rtl/dd_sync.sv
// Multi-stage synchronizer for an asynchronous single-bit input. The reset
// value is selectable so idle-high bus lines come out of reset without a
// false edge.
module dd_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // shift the asynchronous input through the synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/i2c_slave.sv
// I2C target: START/STOP decode, 7-bit address match, register pointer load,
// auto-incrementing byte writes and reads toward a local register file.
//
//   state      | meaning
//   IDLE_S     | bus free or transaction not addressed to us
//   ADDR_S     | shifting in address + R/W bit
//   ADDR_ACK_S | address matched, ACKing it
//   PTR_S      | receiving register pointer byte, then ACK
//   WDATA_S    | receiving write data byte, strobe, ACK
//   RDATA_S    | lead-in (cnt=9) then shifting out read byte
//   RACK_S     | waiting for master ACK/NACK of read byte
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h1A,
    parameter int         REG_ADDR_W = 8,
    parameter int         NUM_SYNC   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl,
    inout  wire                   sda,
    output logic                  reg_wr_en,
    output logic                  reg_rd_en,
    output logic [REG_ADDR_W-1:0] reg_addr,
    output logic [7:0]            reg_wr_data,
    input  logic [7:0]            reg_rd_data,
    input  logic                  reg_rd_valid,
    output logic                  busy
);

    logic                  scl_s, sda_s, scl_d, sda_d;
    logic                  scl_rise, scl_fall, start_det, stop_det;
    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [7:0]            shreg;
    logic [7:0]            byte_in;
    logic [REG_ADDR_W-1:0] ptr;
    logic                  sda_oe;
    logic                  rw;

    dd_sync #(.STAGES(NUM_SYNC), .RST_VAL(1'b1)) u_scl_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (scl),
        .q     (scl_s)
    );

    dd_sync #(.STAGES(NUM_SYNC), .RST_VAL(1'b1)) u_sda_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sda),
        .q     (sda_s)
    );

    // one-cycle delayed copies for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_s;
            sda_d <= sda_s;
        end
    end

    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign byte_in   = {shreg[6:0], sda_s};

    // sda_oe is cleared by the async reset, so the line is released immediately
    assign sda      = sda_oe ? 1'b0 : 1'bz;
    assign reg_addr = ptr;

    // protocol FSM; START/STOP override any bit-level activity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE_S;
            cnt         <= '0;
            shreg       <= '0;
            ptr         <= '0;
            sda_oe      <= 1'b0;
            rw          <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            reg_wr_data <= '0;
            busy        <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            if (stop_det) begin
                state  <= IDLE_S;
                sda_oe <= 1'b0;
                cnt    <= '0;
                busy   <= 1'b0;
            end else if (start_det) begin
                state  <= ADDR_S;
                sda_oe <= 1'b0;
                cnt    <= '0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE_S: ;
                    ADDR_S: begin
                        if (scl_rise) begin
                            shreg <= byte_in;
                            if (cnt == CNT_BYTE_LAST) begin
                                if (byte_in[7:1] == DEV_ADDR) begin
                                    state <= ADDR_ACK_S;
                                    rw    <= byte_in[0];
                                    busy  <= 1'b1;
                                    cnt   <= CNT_ACK;
                                end else begin
                                    state <= IDLE_S;
                                    cnt   <= '0;
                                end
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end
                    end
                    ADDR_ACK_S: begin
                        if (scl_fall && cnt == CNT_ACK) begin
                            sda_oe <= ~ACK_BIT;
                            cnt    <= CNT_HOLD;
                        end else if (scl_fall && cnt == CNT_HOLD && !rw) begin
                            sda_oe <= 1'b0;
                            cnt    <= '0;
                            state  <= PTR_S;
                        end else if (scl_rise && cnt == CNT_HOLD && rw) begin
                            // ACK stays driven; the lead-in fall swaps it for the MSB
                            reg_rd_en <= 1'b1;
                            shreg     <= RD_IDLE_BYTE;
                            state     <= RDATA_S;
                        end
                    end
                    PTR_S, WDATA_S: begin
                        if (scl_rise && cnt < CNT_ACK) begin
                            shreg <= byte_in;
                            cnt   <= cnt + 4'd1;
                            if (cnt == CNT_BYTE_LAST) begin
                                if (state == PTR_S) begin
                                    ptr <= REG_ADDR_W'(byte_in);
                                end else begin
                                    reg_wr_en   <= 1'b1;
                                    reg_wr_data <= byte_in;
                                end
                            end
                        end else if (scl_fall && cnt == CNT_ACK) begin
                            sda_oe <= ~ACK_BIT;
                            cnt    <= CNT_HOLD;
                        end else if (scl_fall && cnt == CNT_HOLD) begin
                            sda_oe <= 1'b0;
                            cnt    <= '0;
                            if (state == WDATA_S) begin
                                ptr <= ptr + 1'b1;
                            end
                            state <= WDATA_S;
                        end
                    end
                    RDATA_S: begin
                        if (scl_fall && cnt != CNT_ACK) begin
                            sda_oe <= ~shreg[7];
                            shreg  <= {shreg[6:0], 1'b1};
                            if (cnt == CNT_HOLD) begin
                                cnt <= '0;
                            end
                        end else if (scl_fall) begin
                            sda_oe <= 1'b0;
                            cnt    <= '0;
                            state  <= RACK_S;
                        end else if (scl_rise && cnt < CNT_ACK) begin
                            cnt <= cnt + 4'd1;
                        end else if (cnt == CNT_HOLD && reg_rd_valid) begin
                            shreg <= reg_rd_data;
                        end
                    end
                    RACK_S: begin
                        if (scl_rise) begin
                            if (sda_s == NACK_BIT) begin
                                state <= IDLE_S;
                                busy  <= 1'b0;
                            end else begin
                                ptr       <= ptr + 1'b1;
                                reg_rd_en <= 1'b1;
                                shreg     <= RD_IDLE_BYTE;
                                cnt       <= CNT_HOLD;
                                state     <= RDATA_S;
                            end
                        end
                    end
                    default: state <= IDLE_S;
                endcase
            end
        end
    end

endmodule
